// File: rtl/alu_mc.sv
// alu_mc: handshaked multi-cycle RV32I/M ALU with an iterative restoring divider.
// Non-divide ops and divide special cases complete in one cycle; normal divides take XLEN+1.
module alu_mc #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    state_t state, state_nx;
    logic [XLEN-1:0] alu_res, sra, a_mag, b_mag, quo, rem, dvsr, q_nx, r_nx;
    logic [2*XLEN-1:0] prod, ma, mb;
    logic [XLEN:0] sh, diff;
    logic [SHW-1:0] cnt;
    logic alu_ill, is_div, sgn, div0, ovf, go_div, a_neg, b_neg, neg_q, neg_r, is_rem;
    assign sra = $signed(rs1) >>> rs2[SHW-1:0];
    // one shared multiplier: operands are zero-extended only for MULHU
    assign ma = {{XLEN{(op != 5'b10011) & rs1[XLEN-1]}}, rs1};
    assign mb = {{XLEN{(op != 5'b10011) & rs2[XLEN-1]}}, rs2};
    assign prod = ma * mb;
    assign is_div = op[4:2] == 3'b101;
    assign sgn = is_div && !op[0];
    assign div0 = rs2 == '0;
    assign ovf = sgn && rs1 == {1'b1, {(XLEN-1){1'b0}}} && &rs2;
    assign go_div = is_div && !div0 && !ovf;
    assign a_neg = sgn && rs1[XLEN-1];
    assign b_neg = sgn && rs2[XLEN-1];
    assign a_mag = a_neg ? -rs1 : rs1;
    assign b_mag = b_neg ? -rs2 : rs2;
    assign sh = {rem, quo[XLEN-1]};
    assign diff = sh - {1'b0, dvsr};
    assign q_nx = {quo[XLEN-2:0], ~diff[XLEN]};
    assign r_nx = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    // divide entries hold the single-cycle special-case answers; normal divides overwrite later
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op)
            5'b00000: alu_res = rs1 + rs2;
            5'b01000: alu_res = rs1 - rs2;
            5'b00111: alu_res = rs1 & rs2;
            5'b00110: alu_res = rs1 | rs2;
            5'b00100: alu_res = rs1 ^ rs2;
            5'b00001: alu_res = rs1 << rs2[SHW-1:0];
            5'b00101: alu_res = rs1 >> rs2[SHW-1:0];
            5'b01101: alu_res = sra;
            5'b00010: alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            5'b00011: alu_res = {{(XLEN-1){1'b0}}, rs1 < rs2};
            5'b01111: alu_res = prod[XLEN-1:0];
            5'b10000, 5'b10011: alu_res = prod[2*XLEN-1:XLEN];
            5'b10100, 5'b10101: alu_res = div0 ? '1 : rs1;
            5'b10110, 5'b10111: alu_res = div0 ? rs1 : '0;
            default: alu_ill = 1'b1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (in_valid ? (go_div ? DIV : DONE) : IDLE) :
                   state == DIV  ? (&cnt ? DONE : DIV) :
                   (out_ready ? IDLE : DONE);
    end
    always_comb begin
        in_ready = state == IDLE;
        busy = state == DIV;
        out_valid = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            illegal <= 1'b0;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dvsr <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            is_rem <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            result <= alu_res;
            illegal <= alu_ill;
            cnt <= '0;
            quo <= a_mag;
            rem <= '0;
            dvsr <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            is_rem <= op[1];
        end else if (state == DIV) begin
            quo <= q_nx;
            rem <= r_nx;
            cnt <= cnt + 1'b1;
            if (&cnt) result <= is_rem ? (neg_r ? -r_nx : r_nx) : (neg_q ? -q_nx : q_nx);
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors feed a scoreboard queue; a negedge monitor checks every completed result.
module tb_alu_mc;
    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b01000, AND_ = 5'b00111, OR_ = 5'b00110,
        XOR_ = 5'b00100, SLL = 5'b00001, SRL = 5'b00101, SRA = 5'b01101, SLT = 5'b00010,
        SLTU = 5'b00011, MUL = 5'b01111, MULH = 5'b10000, MULHU = 5'b10011, DIV = 5'b10100,
        DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [4:0] op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic in_ready, out_valid, illegal, busy;
    logic [31:0] result;
    typedef struct {
        logic [31:0] res;
        logic ill;
        int lat;
        int bsy;
        int acc;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0, bcnt = 0;
    bit seen = 0;
    alu_mc #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt = 0;
            seen = 0;
        end else begin
            if (busy) bcnt++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    if (!seen) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected: out_valid=1 with nothing outstanding, result %h", result);
                        seen = 1;
                    end
                end else begin
                    if (!seen) begin
                        chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                        seen = 1;
                    end
                    if (out_ready) begin
                        chk("result", 64'(result), 64'(sb[0].res));
                        chk("illegal", 64'(illegal), 64'(sb[0].ill));
                        chk("busy_cycles", 64'(bcnt), 64'(sb[0].bsy));
                        void'(sb.pop_front());
                        bcnt = 0;
                        seen = 0;
                    end
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic il, input int lat, input int bsy,
                         input bit push = 1);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        op = o;
        rs1 = a;
        rs2 = b;
        in_valid = 1;
        if (push) sb.push_back('{r, il, lat, bsy, cyc});
        tick();
        in_valid = 0;
        op = 5'($urandom);
        rs1 = $urandom;
        rs2 = $urandom;
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
        tick();
    endtask
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        repeat (3) tick();
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_illegal", 64'(illegal), 64'd0);
        rst_n = 1;
        tick();
        issue(SRA, 32'hF000_0000, 4, 32'hFF00_0000, 0, 1, 0);
        issue(SRL, 32'hF000_0000, 4, 32'h0F00_0000, 0, 1, 0);
        issue(SLT, 32'hF000_0000, 4, 32'd1, 0, 1, 0);
        issue(SLTU, 32'hF000_0000, 4, 32'd0, 0, 1, 0);
        issue(SUB, 32'hF000_0000, 4, 32'hEFFF_FFFC, 0, 1, 0);
        issue(ADD, 32'hF000_0000, 4, 32'hF000_0004, 0, 1, 0);
        issue(SLL, 32'hF000_0000, 4, 32'h0000_0000, 0, 1, 0);
        issue(SLL, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, 0, 1, 0);
        issue(AND_, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0, 1, 0);
        issue(OR_, 32'hF000_0000, 4, 32'hF000_0004, 0, 1, 0);
        issue(XOR_, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 0, 1, 0);
        issue(MUL, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 0, 1, 0);
        issue(MULH, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 0, 1, 0);
        issue(MULHU, 32'hFFFF_FFFF, 2, 32'h0000_0001, 0, 1, 0);
        issue(DIV, -32'sd7, 2, 32'hFFFF_FFFD, 0, 33, 32);
        issue(REM, -32'sd7, 2, 32'hFFFF_FFFF, 0, 33, 32);
        issue(DIVU, 100, 7, 32'd14, 0, 33, 32);
        issue(REMU, 100, 7, 32'd2, 0, 33, 32);
        issue(DIV, 32'h8000_0000, 2, 32'hC000_0000, 0, 33, 32);
        issue(REM, 7, -32'sd2, 32'd1, 0, 33, 32);
        issue(DIV, 5, 0, 32'hFFFF_FFFF, 0, 1, 0);
        issue(REMU, 5, 0, 32'd5, 0, 1, 0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 0);
        issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, 0);
        issue(5'b11111, 3, 4, 32'd0, 1, 1, 0);
        issue(5'b01001, 3, 4, 32'd0, 1, 1, 0);
        drain();
        out_ready = 0;
        issue(ADD, 3, 4, 32'd7, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), 64'd7);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            in_valid = i[0];
            op = SUB;
            rs1 = 100;
            rs2 = 1;
            tick();
        end
        in_valid = 0;
        out_ready = 1;
        tick();
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_out_valid_after", 64'(out_valid), 64'd0);
        chk("bp_queue_empty", 64'(sb.size()), 64'd0);
        issue(DIV, 1000, 3, 32'd0, 0, 33, 32, 0);
        repeat (9) tick();
        rst_n = 0;
        tick();
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1;
        tick();
        issue(ADD, 3, 4, 32'd7, 0, 1, 0);
        issue(5'b11111, 32'h1234_5678, 32'h9, 32'd0, 1, 1, 0);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
